deparser: RTL
=============

Name: deparser

Overview:
- Inverse of the packet parser. Takes one PHV per packet from the match-action pipeline and the original packet from the upstream packet FIFO.
- Overwrites header bytes in the first 128 bytes (4×256b segments) with PHV container values, then re-emits the full packet on an AXI-Stream master.
- Deparse actions (which container goes to which byte offset) come from a 16-entry action RAM indexed by PHV vlan_id[7:4].

Parameters:
C_S_AXIS_DATA_WIDTH, 256, data bus width
C_S_AXIS_TUSER_WIDTH, 128, tuser width
PKT_HDR_LEN, 1124, PHV width
NUM_DEPARSE_ACT, 10, actions per RAM entry (16b each)

Ports:
axis_clk  in  1  clock
aresetn  in  1  synchronous active-low reset
phv_in  in  PKT_HDR_LEN  PHV
phv_valid  in  1  PHV valid
phv_ready  out  1  PHV accepted when valid&ready
s_axis_tdata/tuser/tkeep/tvalid/tlast  in  256/128/32/1/1  packet from FIFO
s_axis_tready  out  1  packet backpressure
m_axis_tdata/tuser/tkeep/tvalid/tlast  out  256/128/32/1/1  rebuilt packet
m_axis_tready  in  1  downstream backpressure
ctrl_wr_ram_addr  in  4  action RAM write address
ctrl_wr_ram_data  in  160  10 actions; action[0] at [159:144], action[9] at [15:0]
ctrl_wr_ram_en  in  1  action RAM write strobe

Behaviour:
- Clock and reset: axis_clk; aresetn is synchronous, active-low.
- Reset values: state=IDLE, phv_ready=0, s_axis_tready=0, all m_axis_* outputs=0, header buffer=0, segment count=0.
- PHV layout, LSB first:
  - tuser [127:0]
  - vlan_id [140:129]
  - 2B container i at 356+16i
  - 4B container i at 484+32i
  - 6B container i at 740+48i
  - Containers are big-endian in the PHV. Before insertion, swap each back to wire byte order: the container MS byte goes to the lowest packet byte.
- Action format [15:0]:
  - [0] valid
  - [3:1] container index
  - [5:4] type: 01=2B, 10=4B, 11=6B, 00=none
  - [12:6] byte offset 0..127
  - [15:13] reserved
- Packet byte k = header buffer bits [8k+:8]; segment n occupies bytes 32n..32n+31.
- IDLE:
  - phv_ready=1, s_axis_tready=0.
  - On phv_valid: latch PHV and drive RAM read address vlan_id[7:4] → WAIT_RAM.
- WAIT_RAM: one cycle for the RAM's 1-cycle read latency; latch the 10 actions → COLLECT.
- COLLECT:
  - s_axis_tready=1.
  - Each beat: store tdata into segment n, store tkeep[n], record tlast.
  - After 4 beats or on tlast → DEPARSE. Record seg_cnt (1..4) and last_in_hdr.
- DEPARSE (one cycle):
  - Apply all valid actions to the buffer combinationally and register the result.
  - Ordering: action 9 applied last, so higher index wins on overlap.
  - Skip an action when offset+size>128 or type=00.
  - Bytes written beyond seg_cnt segments are don't-care but must not extend the packet.
- FLUSH_HDR:
  - m_axis_tvalid=1, presenting segment j (registered outputs).
  - tuser = latched PHV tuser on j=0, else 0.
  - tlast = (j==seg_cnt-1) && last_in_hdr.
  - j advances only on m_axis_tready.
  - After the final header beat: if last_in_hdr → IDLE, else → FLUSH_REST.
- FLUSH_REST:
  - Combinational pass-through: m_axis_* = s_axis_* with tuser=0; s_axis_tready = m_axis_tready.
  - On accepted tlast → IDLE.
- Backpressure: m_axis data must be held stable while tvalid&!tready. No beat may be dropped or duplicated.
- Same-cycle events: an action RAM write in the same cycle as a read of the same address returns the old data.
- Reset mid-packet: return to IDLE. Remaining packet bytes are upstream's responsibility; no partial output is held.
- Throughput: one packet in flight. Per-packet overhead is 3 cycles (IDLE, WAIT_RAM, DEPARSE) plus the header beats.

Decomposition:
- Shared package: PHV field offsets, action bit-field positions, type encodings, header segment count (4).
- Sub-module deparse_act_ram:
  - Simple dual-port, 16×160.
  - Write port on axis_clk.
  - Registered 1-cycle read.
  - Behavioural RAM, no IP core.

Test Plan:
1. Reset held 5 cycles with phv_valid=1 and s_axis_tvalid=1 → phv_ready=0, s_axis_tready=0, m_axis_tvalid=0 throughout.
2. RAM[2] action0 = 4B, idx1, offset 26, valid. PHV vlan_id=0x020, 4B[1]=0x0A000001. 3-beat packet with tlast on beat 3 → bytes 26..29 out = 0A 00 00 01; all other bytes unchanged; 3 output beats; tlast on beat 3; beat-0 tuser = PHV tuser.
3. 6-beat packet, action 6B idx0 offset 0, 6B[0]=0x112233445566 → output bytes 0..5 = 11 22 33 44 55 66; beats 5–6 passed through bit-exact; tlast on beat 6 only.
4. Actions 0 and 9 both target offset 12, 2B type, values 0x0800 and 0x86DD → bytes 12..13 = 86 DD.
5. 1-beat packet with tkeep=0x0000FFFF; action offset 120 (beyond data) and action offset 126 type 6B (overflow) → first write has no visible effect, second is skipped; one beat out with tkeep=0x0000FFFF, tlast=1.
6. m_axis_tready toggled 1,0,0,1 during a 5-beat packet → output beat sequence identical to the tready=1 run; tdata stable while stalled.

Source files
------------

// File: rtl/deparser_pkg.sv
// Shared definitions for the deparser: PHV field offsets, action word layout,
// container type encodings and FSM state codes.
package deparser_pkg;

    localparam int PHV_TUSER_LSB = 0;
    localparam int PHV_TUSER_W   = 128;
    localparam int PHV_VLAN_LSB  = 129;
    localparam int PHV_VLAN_W    = 12;
    localparam int PHV_C2_LSB    = 356;
    localparam int PHV_C4_LSB    = 484;
    localparam int PHV_C6_LSB    = 740;

    localparam int ACT_W       = 16;
    localparam int RAM_ADDR_W  = 4;
    localparam int NUM_HDR_SEG = 4;
    localparam int HDR_BYTES   = 128;

    localparam logic [1:0] ACT_TYPE_NONE = 2'b00;
    localparam logic [1:0] ACT_TYPE_2B   = 2'b01;
    localparam logic [1:0] ACT_TYPE_4B   = 2'b10;
    localparam logic [1:0] ACT_TYPE_6B   = 2'b11;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_RAM   = 3'd1;
    localparam logic [2:0] S_COLLECT    = 3'd2;
    localparam logic [2:0] S_DEPARSE    = 3'd3;
    localparam logic [2:0] S_FLUSH_HDR  = 3'd4;
    localparam logic [2:0] S_FLUSH_REST = 3'd5;

    typedef struct packed {
        logic [2:0] rsvd;
        logic [6:0] offset;
        logic [1:0] ctype;
        logic [2:0] idx;
        logic       valid;
    } deparse_act_t;

    // The type code doubles as the container size in 16-bit units.
    function automatic logic [3:0] act_size(input logic [1:0] ctype);
        return {1'b0, ctype, 1'b0};
    endfunction

endpackage

// File: rtl/deparse_act_ram.sv
// Simple dual-port action RAM: synchronous write, registered read.
// A read of the address being written returns the previous contents.
module deparse_act_ram
    import deparser_pkg::*;
#(
    parameter int DATA_W = 160
) (
    input  logic                  axis_clk,
    input  logic                  wr_en,
    input  logic [RAM_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [RAM_ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] mem [2**RAM_ADDR_W];
    logic [DATA_W-1:0] rd_data_reg;

    always_ff @(posedge axis_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_reg <= mem[rd_addr];
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/deparser.sv
// Packet deparser: rewrites header bytes in the first four data beats with PHV
// container values, then re-emits the whole packet on the AXI-Stream master.
module deparser
    import deparser_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int PKT_HDR_LEN          = 1124,
    parameter int NUM_DEPARSE_ACT      = 10
) (
    input  logic                              axis_clk,
    input  logic                              aresetn,
    input  logic [PKT_HDR_LEN-1:0]            phv_in,
    input  logic                              phv_valid,
    output logic                              phv_ready,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    input  logic [RAM_ADDR_W-1:0]             ctrl_wr_ram_addr,
    input  logic [ACT_W*NUM_DEPARSE_ACT-1:0]  ctrl_wr_ram_data,
    input  logic                              ctrl_wr_ram_en
);

    localparam int DW     = C_S_AXIS_DATA_WIDTH;
    localparam int KW     = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW     = C_S_AXIS_TUSER_WIDTH;
    localparam int HDR_W  = NUM_HDR_SEG * DW;
    localparam int CONT_W = PKT_HDR_LEN - PHV_C2_LSB;

    logic [2:0]                          state_reg;
    logic [PHV_TUSER_W-1:0]              phv_tuser_reg;
    logic [CONT_W-1:0]                   phv_cont_reg;
    deparse_act_t [NUM_DEPARSE_ACT-1:0]  act_reg;
    logic [HDR_W-1:0]                    hdr_reg;
    logic [HDR_W-1:0]                    hdr_next;
    logic [NUM_HDR_SEG-1:0][KW-1:0]      keep_reg;
    logic [1:0]                          seg_idx_reg;
    logic [2:0]                          seg_cnt_reg;
    logic                                last_in_hdr_reg;
    logic [1:0]                          out_idx_reg;
    logic [1:0]                          out_idx_next;
    logic [DW-1:0]                       out_tdata_reg;
    logic [UW-1:0]                       out_tuser_reg;
    logic [KW-1:0]                       out_tkeep_reg;
    logic                                out_tvalid_reg;
    logic                                out_tlast_reg;

    logic [ACT_W*NUM_DEPARSE_ACT-1:0]    ram_rd_data;
    deparse_act_t [NUM_DEPARSE_ACT-1:0]  ram_actions;
    logic                                pass_through;
    logic                                phv_unused;

    assign phv_unused = ^{phv_in[PHV_VLAN_LSB-1 -: 1], phv_in[PHV_C2_LSB-1:PHV_VLAN_LSB+8],
                          phv_in[PHV_VLAN_LSB+3:PHV_VLAN_LSB], s_axis_tuser};

    deparse_act_ram #(
        .DATA_W (ACT_W*NUM_DEPARSE_ACT)
    ) u_act_ram (
        .axis_clk (axis_clk),
        .wr_en    (ctrl_wr_ram_en),
        .wr_addr  (ctrl_wr_ram_addr),
        .wr_data  (ctrl_wr_ram_data),
        .rd_addr  (phv_in[PHV_VLAN_LSB+4 +: RAM_ADDR_W]),
        .rd_data  (ram_rd_data)
    );

    // Action 0 sits in the most significant slice of the RAM word.
    generate
        for (genvar gi = 0; gi < NUM_DEPARSE_ACT; gi++) begin : g_act
            assign ram_actions[gi] = ram_rd_data[ACT_W*(NUM_DEPARSE_ACT-gi)-1 -: ACT_W];
        end
    endgenerate

    // Actions applied in index order so the highest index wins on overlap.
    always_comb begin
        deparse_act_t act;
        logic [3:0]   size;
        logic [47:0]  cval;
        logic [47:0]  cval_lj;
        logic [6:0]   pos;
        hdr_next = hdr_reg;
        act      = '0;
        size     = '0;
        cval     = '0;
        cval_lj  = '0;
        pos      = '0;
        for (int a = 0; a < NUM_DEPARSE_ACT; a++) begin
            act  = act_reg[a];
            size = act_size(act.ctype);
            case (act.ctype)
                ACT_TYPE_2B: cval = {32'd0, phv_cont_reg[16*act.idx +: 16]};
                ACT_TYPE_4B: cval = {16'd0, phv_cont_reg[(PHV_C4_LSB-PHV_C2_LSB) + 32*act.idx +: 32]};
                ACT_TYPE_6B: cval = phv_cont_reg[(PHV_C6_LSB-PHV_C2_LSB) + 48*act.idx +: 48];
                default:     cval = '0;
            endcase
            // Left-justify so the container's MS byte lands on the lowest packet byte.
            cval_lj = cval << (8 * (6 - size));
            if (act.valid && act.ctype != ACT_TYPE_NONE &&
                ({1'b0, act.offset} + {4'd0, size}) <= 8'(HDR_BYTES)) begin
                for (int b = 0; b < 6; b++) begin
                    if (4'(b) < size) begin
                        pos = act.offset + 7'(b);
                        hdr_next[{pos, 3'b000} +: 8] = cval_lj[47-8*b -: 8];
                    end
                end
            end
        end
    end

    assign out_idx_next = out_idx_reg + 2'd1;

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            state_reg       <= S_IDLE;
            phv_tuser_reg   <= '0;
            phv_cont_reg    <= '0;
            act_reg         <= '0;
            hdr_reg         <= '0;
            keep_reg        <= '0;
            seg_idx_reg     <= '0;
            seg_cnt_reg     <= '0;
            last_in_hdr_reg <= 1'b0;
            out_idx_reg     <= '0;
            out_tdata_reg   <= '0;
            out_tuser_reg   <= '0;
            out_tkeep_reg   <= '0;
            out_tvalid_reg  <= 1'b0;
            out_tlast_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (phv_valid) begin
                        phv_tuser_reg <= phv_in[PHV_TUSER_LSB +: PHV_TUSER_W];
                        phv_cont_reg  <= phv_in[PKT_HDR_LEN-1:PHV_C2_LSB];
                        state_reg     <= S_WAIT_RAM;
                    end
                end
                S_WAIT_RAM: begin
                    act_reg     <= ram_actions;
                    seg_idx_reg <= '0;
                    state_reg   <= S_COLLECT;
                end
                S_COLLECT: begin
                    if (s_axis_tvalid) begin
                        hdr_reg[seg_idx_reg*DW +: DW] <= s_axis_tdata;
                        keep_reg[seg_idx_reg]         <= s_axis_tkeep;
                        if (s_axis_tlast || seg_idx_reg == 2'(NUM_HDR_SEG-1)) begin
                            seg_cnt_reg     <= {1'b0, seg_idx_reg} + 3'd1;
                            last_in_hdr_reg <= s_axis_tlast;
                            state_reg       <= S_DEPARSE;
                        end else begin
                            seg_idx_reg <= seg_idx_reg + 2'd1;
                        end
                    end
                end
                S_DEPARSE: begin
                    hdr_reg        <= hdr_next;
                    out_idx_reg    <= '0;
                    out_tdata_reg  <= hdr_next[DW-1:0];
                    out_tkeep_reg  <= keep_reg[0];
                    out_tuser_reg  <= UW'(phv_tuser_reg);
                    out_tlast_reg  <= (seg_cnt_reg == 3'd1) && last_in_hdr_reg;
                    out_tvalid_reg <= 1'b1;
                    state_reg      <= S_FLUSH_HDR;
                end
                S_FLUSH_HDR: begin
                    if (m_axis_tready) begin
                        if ({1'b0, out_idx_reg} == seg_cnt_reg - 3'd1) begin
                            out_tdata_reg  <= '0;
                            out_tuser_reg  <= '0;
                            out_tkeep_reg  <= '0;
                            out_tvalid_reg <= 1'b0;
                            out_tlast_reg  <= 1'b0;
                            state_reg      <= last_in_hdr_reg ? S_IDLE : S_FLUSH_REST;
                        end else begin
                            out_idx_reg   <= out_idx_next;
                            out_tdata_reg <= hdr_reg[out_idx_next*DW +: DW];
                            out_tkeep_reg <= keep_reg[out_idx_next];
                            out_tuser_reg <= '0;
                            out_tlast_reg <= ({1'b0, out_idx_next} == seg_cnt_reg - 3'd1) &&
                                             last_in_hdr_reg;
                        end
                    end
                end
                S_FLUSH_REST: begin
                    if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign pass_through  = (state_reg == S_FLUSH_REST);
    assign phv_ready     = aresetn && (state_reg == S_IDLE);
    assign s_axis_tready = aresetn && ((state_reg == S_COLLECT) || (pass_through && m_axis_tready));

    assign m_axis_tdata  = pass_through ? s_axis_tdata  : out_tdata_reg;
    assign m_axis_tkeep  = pass_through ? s_axis_tkeep  : out_tkeep_reg;
    assign m_axis_tlast  = pass_through ? s_axis_tlast  : out_tlast_reg;
    assign m_axis_tvalid = pass_through ? s_axis_tvalid : out_tvalid_reg;
    assign m_axis_tuser  = pass_through ? '0            : out_tuser_reg;

endmodule
